// File: rtl/vector_multicycle_ctrl.sv
// Multicycle fetch/decode/exec/mem/wb sequencer with vector beat splitting.
// Optional perf counters (cyc_cnt, ret_cnt) enabled by VMC_PERF_CNT_EN.
module vector_multicycle_ctrl #(
  parameter int BEATS = 4,
  parameter int BW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          imem_ack,
  input  logic [1:0]    Op,
  input  logic [1:0]    Funct_FO,
  input  logic          cond_pass,
  input  logic          dmem_ack,
  output logic          imem_req,
  output logic          ir_write,
  output logic          pc_write,
  output logic          dmem_req,
  output logic          MemW,
  output logic          RegW,
  output logic          MemToReg,
  output logic          ALUSrc,
  output logic [BW-1:0] beat_idx,
  output logic          busy,
  output logic          illegal
`ifdef VMC_PERF_CNT_EN
  ,
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          last_beat;

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign beat_idx  = beat_q;

  // State and beat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next state; run is only consulted at instruction boundaries
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        beat_d = '0;
        if (!cond_pass)        state_d = S_FETCH;
        else if (Op == 2'b00)  state_d = S_EXEC;
        else if (Op == 2'b01)  state_d = S_MEM;
        else                   state_d = S_FETCH;
      end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (Funct_FO[0]) begin
            state_d = S_WB;
          end else if (!last_beat) begin
            beat_d = beat_q + 1'b1;
          end else begin
            beat_d  = '0;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_WB: begin
        if (!last_beat) begin
          beat_d  = beat_q + 1'b1;
          state_d = S_MEM;
        end else begin
          beat_d  = '0;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs decoded from state; fetch strobes follow imem_ack
  always_comb begin
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    dmem_req = 1'b0;
    MemW     = 1'b0;
    RegW     = 1'b0;
    MemToReg = 1'b0;
    ALUSrc   = 1'b0;
    illegal  = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
        pc_write = imem_ack;
      end
      S_DECODE: begin
        illegal = cond_pass & Op[1];
      end
      S_EXEC: begin
        ALUSrc = Funct_FO[1];
        RegW   = 1'b1;
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        dmem_req = 1'b1;
        MemW     = ~Funct_FO[0];
      end
      S_WB: begin
        RegW     = 1'b1;
        MemToReg = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef VMC_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ret_q, ret_d;
  logic        retire;

  // Counter updates; retire marks the last cycle of a completed instruction
  always_comb begin
    retire = (state_q == S_EXEC)
           | ((state_q == S_MEM) & dmem_ack & ~Funct_FO[0] & last_beat)
           | ((state_q == S_WB) & last_beat);
    cyc_d  = busy   ? cyc_q + 32'd1 : cyc_q;
    ret_d  = retire ? ret_q + 32'd1 : ret_q;
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_vector_multicycle_ctrl.sv
// Scoreboard bench for vector_multicycle_ctrl (BEATS=4, BW=2).
// Perf counter checks are compiled in when VMC_PERF_CNT_EN is defined.
module tb_vector_multicycle_ctrl;
  localparam int BEATS = 4;
  localparam int BW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run, imem_ack, cond_pass, dmem_ack;
  logic [1:0] Op, Funct_FO;
  logic imem_req, ir_write, pc_write, dmem_req, MemW;
  logic RegW, MemToReg, ALUSrc, busy, illegal;
  logic [BW-1:0] beat_idx;
`ifdef VMC_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic [3:0] exp_rw[$];
  logic [3:0] obs_rw[$];
  logic [2:0] exp_dm[$];
  logic [2:0] obs_dm[$];
  int wcnt, n_irw, n_req, n_memw, n_ill, n_alu0;
  logic saw_rw;

  always #5 clk = ~clk;

  vector_multicycle_ctrl #(.BEATS(BEATS), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_ack(imem_ack),
    .Op(Op), .Funct_FO(Funct_FO), .cond_pass(cond_pass),
    .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_write(ir_write),
    .pc_write(pc_write), .dmem_req(dmem_req), .MemW(MemW),
    .RegW(RegW), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
    .beat_idx(beat_idx), .busy(busy), .illegal(illegal)
`ifdef VMC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  task automatic cyc(input int dly);
    @(negedge clk);
    saw_rw = RegW;
    if (RegW) obs_rw.push_back({MemToReg, ALUSrc & ~MemToReg, beat_idx});
    if (ir_write) n_irw++;
    if (illegal) n_ill++;
    if (dmem_req) begin
      n_req++;
      if (MemW) n_memw++;
      if (!ALUSrc) n_alu0++;
      if (wcnt >= dly) begin
        dmem_ack = 1'b1;
        wcnt = 0;
        obs_dm.push_back({MemW, beat_idx});
      end else begin
        dmem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      dmem_ack = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0; imem_ack = 1'b1; cond_pass = 1'b1;
    dmem_ack = 1'b0; Op = 2'b00; Funct_FO = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rw.delete(); obs_rw.delete();
    exp_dm.delete(); obs_dm.delete();
    wcnt = 0; n_irw = 0; n_req = 0; n_memw = 0; n_ill = 0; n_alu0 = 0;
  endtask

  task automatic test_reset();
    run = 1'b0; imem_ack = 1'b0; cond_pass = 1'b0;
    dmem_ack = 1'b0; Op = 2'b00; Funct_FO = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req, ir_write, pc_write, dmem_req, MemW, RegW,
         MemToReg, ALUSrc, busy, illegal} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0", {imem_req, ir_write,
        pc_write, dmem_req, MemW, RegW, MemToReg, ALUSrc, busy, illegal});
    end
    total++;
    if (beat_idx !== 2'd0) begin
      bad++; $display("FAIL reset_beat got=%0d want=0", beat_idx);
    end
`ifdef VMC_PERF_CNT_EN
    total++;
    if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", cyc_cnt, ret_cnt);
    end
`endif
  endtask

  task automatic test_dp_imm();
    logic [15:0] rw_mask, irw_mask;
    logic [3:0] e, o;
    do_reset();
    Op = 2'b00; Funct_FO = 2'b10; run = 1'b1;
    rw_mask = '0; irw_mask = '0;
    for (int i = 0; i < 9; i++) begin
      exp_rw.push_back(4'b0100);
      cyc(0);
      rw_mask[i] = RegW;
      irw_mask[i] = ir_write & pc_write;
      if (obs_rw.size() > 0) begin
        o = obs_rw.pop_front(); e = exp_rw.pop_front();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL dp_rw got=%h want=%h", o, e);
        end
      end
    end
    exp_rw.delete();
    total++;
    if (rw_mask !== 16'h0124) begin
      bad++; $display("FAIL dp_rw_timing got=%h want=0124", rw_mask);
    end
    total++;
    if (irw_mask !== 16'h0049) begin
      bad++; $display("FAIL dp_fetch_timing got=%h want=0049", irw_mask);
    end
    run = 1'b0;
  endtask

  task automatic test_strv();
    logic [2:0] e, o;
    logic done;
    do_reset();
    Op = 2'b01; Funct_FO = 2'b00; run = 1'b1; done = 1'b0;
    for (int b = 0; b < BEATS; b++) exp_dm.push_back({1'b1, 2'(b)});
    for (int i = 0; i < 80 && !done; i++) begin
      cyc(2);
      if (n_irw > 0) run = 1'b0;
      if (obs_dm.size() > 0) begin
        o = obs_dm.pop_front();
        total++;
        if (exp_dm.size() == 0) begin
          bad++; $display("FAIL st_beat extra got=%h want=none", o);
        end else begin
          e = exp_dm.pop_front();
          if (o !== e) begin
            bad++; $display("FAIL st_beat got=%h want=%h", o, e);
          end
        end
      end
      if (i > 0 && !busy) done = 1'b1;
    end
    total++;
    if (!done || exp_dm.size() != 0) begin
      bad++; $display("FAIL st_done got=%0d left=%0d want=1 left=0", done, exp_dm.size());
    end
    total++;
    if (n_req != 12 || n_memw != 12) begin
      bad++; $display("FAIL st_mem_cycles got=%0d/%0d want=12/12", n_req, n_memw);
    end
    total++;
    if (obs_rw.size() != 0 || n_alu0 != 0) begin
      bad++; $display("FAIL st_no_regw got=%0d/%0d want=0/0", obs_rw.size(), n_alu0);
    end
  endtask

  task automatic test_ldrv();
    logic [3:0] e, o;
    logic [2:0] de, dobs;
    logic done;
    do_reset();
    Op = 2'b01; Funct_FO = 2'b01; run = 1'b1; done = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      exp_rw.push_back({2'b10, 2'(b)});
      exp_dm.push_back({1'b0, 2'(b)});
    end
    for (int i = 0; i < 40 && !done; i++) begin
      cyc(0);
      if (n_irw > 0) run = 1'b0;
      if (obs_rw.size() > 0) begin
        o = obs_rw.pop_front();
        total++;
        if (exp_rw.size() == 0) begin
          bad++; $display("FAIL ld_rw extra got=%h want=none", o);
        end else begin
          e = exp_rw.pop_front();
          if (o !== e) begin
            bad++; $display("FAIL ld_rw got=%h want=%h", o, e);
          end
        end
      end
      if (obs_dm.size() > 0) begin
        dobs = obs_dm.pop_front();
        total++;
        if (exp_dm.size() == 0) begin
          bad++; $display("FAIL ld_beat extra got=%h want=none", dobs);
        end else begin
          de = exp_dm.pop_front();
          if (dobs !== de) begin
            bad++; $display("FAIL ld_beat got=%h want=%h", dobs, de);
          end
        end
      end
      if (i > 0 && !busy) done = 1'b1;
    end
    total++;
    if (!done || exp_rw.size() != 0 || exp_dm.size() != 0) begin
      bad++;
      $display("FAIL ld_done got=%0d left=%0d/%0d want=1 left=0/0",
               done, exp_rw.size(), exp_dm.size());
    end
    total++;
    if (n_req != 4 || n_memw != 0 || n_alu0 != 0) begin
      bad++;
      $display("FAIL ld_mem_cycles got=%0d/%0d/%0d want=4/0/0", n_req, n_memw, n_alu0);
    end
  endtask

  task automatic test_squash_illegal();
    logic [2:0] ill_mask, req_mask;
    do_reset();
    Op = 2'b01; Funct_FO = 2'b01; cond_pass = 1'b0; run = 1'b1;
    repeat (6) cyc(0);
    total++;
    if (n_irw != 3 || n_req != 0 || obs_rw.size() != 0) begin
      bad++;
      $display("FAIL squash got=irw%0d req%0d rw%0d want=irw3 req0 rw0",
               n_irw, n_req, obs_rw.size());
    end
    Op = 2'b10; cond_pass = 1'b1;
    ill_mask = '0; req_mask = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(0);
      ill_mask[i] = illegal;
      req_mask[i] = imem_req;
    end
    total++;
    if (ill_mask !== 3'b010) begin
      bad++; $display("FAIL illegal_pulse got=%b want=010", ill_mask);
    end
    total++;
    if (req_mask !== 3'b101 || obs_rw.size() != 0) begin
      bad++; $display("FAIL illegal_refetch got=%b want=101", req_mask);
    end
    run = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [3:0] e, o;
    logic done;
    do_reset();
    Op = 2'b00; Funct_FO = 2'b00; run = 1'b1; done = 1'b0;
    exp_rw.push_back(4'b0000);
    for (int i = 0; i < 10 && !done; i++) begin
      cyc(0);
      if (saw_rw) run = 1'b0;
      if (obs_rw.size() > 0) begin
        o = obs_rw.pop_front();
        total++;
        if (exp_rw.size() == 0) begin
          bad++; $display("FAIL drop_rw extra got=%h want=none", o);
        end else begin
          e = exp_rw.pop_front();
          if (o !== e) begin
            bad++; $display("FAIL drop_rw got=%h want=%h", o, e);
          end
        end
      end
      if (i > 0 && !busy) done = 1'b1;
    end
    total++;
    if (!done || exp_rw.size() != 0 || n_irw != 1) begin
      bad++;
      $display("FAIL drop_idle got=%0d left=%0d irw=%0d want=1 left=0 irw=1",
               done, exp_rw.size(), n_irw);
    end
`ifdef VMC_PERF_CNT_EN
    total++;
    if (cyc_cnt !== 32'd3 || ret_cnt !== 32'd1) begin
      bad++; $display("FAIL perf got=%0d/%0d want=3/1", cyc_cnt, ret_cnt);
    end
`endif
    repeat (2) cyc(0);
    total++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL drop_stay got=%b%b want=00", busy, imem_req);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic found;
    int mw;
    do_reset();
    Op = 2'b01; Funct_FO = 2'b00; run = 1'b1; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(2);
      if (n_irw > 0) run = 1'b0;
      if (dmem_req && beat_idx == 2'd2) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rst_mem_reach got=0 want=1");
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({dmem_req, MemW, RegW, busy, imem_req, ir_write, pc_write,
         MemToReg, ALUSrc, illegal} !== 10'b0 || beat_idx !== 2'd0) begin
      bad++;
      $display("FAIL rst_mem_outs got=%b beat=%0d want=0 beat=0",
               {dmem_req, MemW, RegW, busy, imem_req, ir_write, pc_write,
                MemToReg, ALUSrc, illegal}, beat_idx);
    end
    mw = 0;
    repeat (3) begin
      @(negedge clk);
      if (MemW || RegW || dmem_req) mw++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (MemW || RegW || dmem_req || busy) mw++;
    end
    total++;
    if (mw != 0) begin
      bad++; $display("FAIL rst_mem_quiet got=%0d want=0", mw);
    end
  endtask

  initial begin
    test_reset();
    test_dp_imm();
    test_strv();
    test_ldrv();
    test_squash_illegal();
    test_run_drop();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
